// File: rtl/event_pulse_stretcher.sv
// event_pulse_stretcher
//   Turns single-cycle status strobes into LED blinks that a person can see.
//   Each blink is ON_CYCLES clocks high, followed by OFF_CYCLES clocks low, so
//   back-to-back events still show up as separate blinks.
//
//   Optional feature macro: PULSE_STRETCH_QUEUE_EN
//     defined   : events that arrive during a blink are counted in 'pending'
//                 (saturating) and each one is replayed as its own blink.
//     undefined : events that arrive during a blink are dropped and set
//                 'overflow'; 'pending' is constant zero.
//
//   Handshake note: there is no handshake. 'evt' is a level, and each rising
//   edge of it is one event. 'led' and 'busy' are registered, and 'pending'
//   and 'overflow' are registered. 'clr' is sampled on every clock edge.
//
//   The FSM state is held in 'state' (type state_t) so that checkers can bind to it.
module event_pulse_stretcher #(
  parameter int ON_CYCLES  = 5,
  parameter int OFF_CYCLES = 5,
  parameter int CNT_W      = 25,
  parameter int QCNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evt,
  input  logic              clr,
  output logic              led,
  output logic              busy,
  output logic [QCNT_W-1:0] pending,
  output logic              overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [QCNT_W-1:0] PEND_MAX = '1;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic             evt_q;
  logic             ev;
  logic             stray;    // event that was not consumed by a blink start
  logic             q_dec;    // a queued event starts a blink this cycle
  logic             pend_nz;
  logic             ovf_set;

  assign ev = evt & ~evt_q;

  // Next-state logic: blink sequencing and classification of incoming events
  always_comb begin
    state_n = state;
    count_n = count;
    stray   = 1'b0;
    q_dec   = 1'b0;
    case (state)
      S_IDLE: begin
        if (ev) begin
          state_n = S_ON;
          count_n = '0;
        end
      end
      S_ON: begin
        stray = ev;
        if (count == ON_LAST) begin
          state_n = S_GAP;
          count_n = '0;
        end else begin
          count_n = count + 1'b1;
        end
      end
      S_GAP: begin
        if (count == OFF_LAST) begin
          count_n = '0;
          if (pend_nz) begin
            // A queued blink goes first. A new event in this cycle joins the queue, so the +1 and -1 cancel.
            state_n = S_ON;
            q_dec   = 1'b1;
            stray   = ev;
          end else if (ev) begin
            state_n = S_ON;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          count_n = count + 1'b1;
          stray   = ev;
        end
      end
      default: begin
        state_n = S_IDLE;
        count_n = '0;
      end
    endcase
  end

  // State, duration counter, edge detector and registered LED/busy outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      count <= '0;
      evt_q <= 1'b0;
      led   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      evt_q <= evt;
      led   <= (state_n == S_ON);
      busy  <= (state_n != S_IDLE);
    end
  end

`ifdef PULSE_STRETCH_QUEUE_EN
  assign pend_nz = |pending;
  // An event is lost only when the queue is full and no queued entry leaves in the same cycle.
  assign ovf_set = stray & ~q_dec & (pending == PEND_MAX);

  // Pending-event counter with a saturating increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      case ({stray, q_dec})
        2'b10:   if (pending != PEND_MAX) pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
    end
  end
`else
  assign pending = '0;
  assign pend_nz = 1'b0;
  // Without a queue, every event that arrives during a blink is lost.
  assign ovf_set = stray & ~q_dec;
`endif

  // Sticky overflow flag: setting it wins over clearing it in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_event_pulse_stretcher.sv
// tb_event_pulse_stretcher
//   Directed bench for event_pulse_stretcher with ON=5, OFF=5 and QCNT_W=4.
//   Its expectations follow PULSE_STRETCH_QUEUE_EN in the same way as the design.
module tb_event_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       evt;
  logic       clr;
  logic       led;
  logic       busy;
  logic [3:0] pending;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       evt;
    logic       clr;
    logic       led;
    logic       busy;
    logic [3:0] pend;
    logic       ovf;
  } vec_t;

  vec_t t1[12];

  event_pulse_stretcher #(
    .ON_CYCLES (5),
    .OFF_CYCLES(5),
    .CNT_W     (25),
    .QCNT_W    (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .evt     (evt),
    .clr     (clr),
    .led     (led),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Compare one value and log it
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: apply inputs for one clock, then check all outputs 1 ns after the edge
  task automatic step(input logic e, input logic c, input logic el, input logic eb,
                      input logic [3:0] ep, input logic eo, input string tag);
    evt = e;
    clr = c;
    @(posedge clk);
    #1;
    chk({tag, ".led"},      int'(led),      int'(el));
    chk({tag, ".busy"},     int'(busy),     int'(eb));
    chk({tag, ".pending"},  int'(pending),  int'(ep));
    chk({tag, ".overflow"}, int'(overflow), int'(eo));
  endtask

  function automatic vec_t mk(input logic e, input logic c, input logic el,
                              input logic eb, input logic [3:0] ep, input logic eo);
    vec_t v;
    v.evt = e; v.clr = c; v.led = el; v.busy = eb; v.pend = ep; v.ovf = eo;
    return v;
  endfunction

  initial begin
    int blinks;
    int guard;
    logic led_prev;

    // Single 1-clock event: 5 clocks ON, 5 clocks gap, then idle
    t1[0] = mk(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    for (int i = 1; i < 5; i++)  t1[i] = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    for (int i = 5; i < 10; i++) t1[i] = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    t1[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    t1[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

    rst = 1'b1;
    evt = 1'b0;
    clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.led",      int'(led),      0);
    chk("reset.busy",     int'(busy),     0);
    chk("reset.pending",  int'(pending),  0);
    chk("reset.overflow", int'(overflow), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      step(t1[i].evt, t1[i].clr, t1[i].led, t1[i].busy, t1[i].pend, t1[i].ovf,
           $sformatf("single[%0d]", i));

    // An event in the final gap cycle with nothing queued goes straight to ON with no idle cycle
    for (int k = 1; k <= 22; k++)
      step(k == 1 || k == 11, 1'b0, (k <= 5) || (k >= 11 && k <= 15), k <= 20, 4'd0, 1'b0,
           $sformatf("b2b[%0d]", k));

    // A level held high for 50 clocks gives exactly one blink
    for (int k = 0; k < 50; k++)
      step(1'b1, 1'b0, k < 5, k < 10, 4'd0, 1'b0, $sformatf("held[%0d]", k));
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, "held.release");
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, "held.idle");

    // Asynchronous reset in the middle of ON, then release it with evt already high
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, "arst.start");
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, "arst.on1");
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, "arst.on2");
    #1 rst = 1'b1;
    #1;
    chk("arst.led",      int'(led),      0);
    chk("arst.busy",     int'(busy),     0);
    chk("arst.pending",  int'(pending),  0);
    chk("arst.overflow", int'(overflow), 0);
    evt = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++)
      step(1'b1, 1'b0, k < 5, k < 10, 4'd0, 1'b0, $sformatf("arst.blink[%0d]", k));
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, "arst.release");

`ifdef PULSE_STRETCH_QUEUE_EN
    // Three events two clocks apart: the queue peaks at 2, then three separate blinks
    for (int k = 1; k <= 32; k++)
      step(k == 1 || k == 3 || k == 5, 1'b0,
           (k <= 5) || (k >= 11 && k <= 15) || (k >= 21 && k <= 25),
           k <= 30,
           (k < 3) ? 4'd0 : (k < 5) ? 4'd1 : (k < 11) ? 4'd2 : (k < 21) ? 4'd1 : 4'd0,
           1'b0, $sformatf("queue3[%0d]", k));

    // Twenty events: the queue saturates at 15, one event is lost, and 19 blinks follow.
    // The event on edge 39 comes with clr, and the overflow set must win.
    blinks   = 0;
    led_prev = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      evt = (k % 2 == 1) && (k <= 39);
      clr = (k == 39);
      @(posedge clk);
      #1;
      if (led && !led_prev) blinks++;
      led_prev = led;
      if (k == 11) chk("sat.cancel_pending", int'(pending), 4);
      if (k == 39) begin
        chk("sat.pending",  int'(pending),  15);
        chk("sat.overflow", int'(overflow), 1);
      end
    end
    evt = 1'b0;
    clr = 1'b0;
    guard = 0;
    while (busy && guard < 400) begin
      @(posedge clk);
      #1;
      if (led && !led_prev) blinks++;
      led_prev = led;
      guard++;
    end
    chk("sat.drain_timeout", int'(busy), 0);
    chk("sat.blinks",        blinks,     19);
    chk("sat.pending_end",   int'(pending),  0);
    chk("sat.overflow_end",  int'(overflow), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "sat.clr");
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, "sat.after_clr");
`else
    // A second event two clocks into ON is dropped: one blink only, and overflow is set
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, "drop.e1");
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, "drop.on1");
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1, "drop.e2");
    for (int k = 4; k <= 5; k++)
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1, $sformatf("drop.on[%0d]", k));
    for (int k = 6; k <= 10; k++)
      step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, $sformatf("drop.gap[%0d]", k));
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, "drop.idle");
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "drop.clr");
    // When an event is dropped in the same clock as clr, overflow must still be set
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, "pri.e1");
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, "pri.on1");
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1, "pri.set_and_clr");
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1, "pri.hold");
    for (int k = 5; k <= 5; k++)
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1, $sformatf("pri.on[%0d]", k));
    for (int k = 6; k <= 10; k++)
      step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, $sformatf("pri.gap[%0d]", k));
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, "pri.idle");
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "pri.clr");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
